// File: rtl/ha_array_accumulator.sv
// ---------------------------------------------------------------------------
// ha_array_accumulator
//
// Purpose:
//   Takes the sum/carry vectors from four half-adder array groups and reduces
//   them to one 17-bit result over several cycles:
//     G_k    = ha_array_k_t + (ha_array_k_b << 2)      (10 bits)
//     result = sum_k G_k << 2k                          (17 bits, max 86615)
//   ADDS_PER_CYCLE groups are folded into the accumulator per ACC cycle,
//   lowest group index first.
//
// Ports:
//   clk                  sole clock, rising edge
//   rst_n                asynchronous active-low reset
//   ha_array_k_b [6:0]   carry vector of group k (k = 0..3)
//   ha_array_k_t [8:0]   sum vector of group k (k = 0..3)
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   product [16:0]       accumulated result, meaningful while out_valid = 1
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//
// Timing:
//   Counting the accept edge as the first edge, out_valid rises on edge
//   4/ADDS_PER_CYCLE + 1. The result is accepted on the edge after that at
//   the earliest, and in_ready returns on that same edge, so a new operand
//   set can be taken every 4/ADDS_PER_CYCLE + 2 cycles.
//
// States:
//   IDLE | waiting for an operand set, in_ready = 1
//   ACC  | adding ADDS_PER_CYCLE shifted groups per cycle into acc
//   DONE | product held, out_valid = 1 until out_ready
// ---------------------------------------------------------------------------
module ha_array_accumulator #(
  parameter int ADDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  ha_array_0_b,
  input  logic [6:0]  ha_array_1_b,
  input  logic [6:0]  ha_array_2_b,
  input  logic [6:0]  ha_array_3_b,
  input  logic [8:0]  ha_array_0_t,
  input  logic [8:0]  ha_array_1_t,
  input  logic [8:0]  ha_array_2_t,
  input  logic [8:0]  ha_array_3_t,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [16:0] product,
  output logic        out_valid,
  input  logic        out_ready
);

  generate
    if (!(ADDS_PER_CYCLE == 1 || ADDS_PER_CYCLE == 2 || ADDS_PER_CYCLE == 4)) begin : g_bad_param
      $error("ha_array_accumulator: ADDS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [2:0] STEP      = 3'(ADDS_PER_CYCLE);
  localparam logic [2:0] LAST_IDX  = 3'(4 - ADDS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [8:0]  t_r [4];
  logic [6:0]  b_r [4];
  logic [2:0]  grp_idx;
  logic [16:0] acc;

  logic [9:0]  grp_val [4];
  logic [16:0] grp_sh  [4];
  logic [16:0] add_sum;
  logic        last_step;

  // Group values come only from the registered operand copy, so the bus
  // inputs are free to change once the accept edge has passed.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      grp_val[k] = {1'b0, t_r[k]} + {1'b0, b_r[k], 2'b00};
      grp_sh[k]  = {7'b0, grp_val[k]} << (2 * k);
    end
  end

  // Slice of groups handled this cycle; grp_idx is always a multiple of
  // ADDS_PER_CYCLE, so the 2-bit index never wraps inside one slice.
  always_comb begin
    add_sum = '0;
    for (int j = 0; j < ADDS_PER_CYCLE; j++) begin
      add_sum = add_sum + grp_sh[grp_idx[1:0] + 2'(j)];
    end
  end

  assign last_step = (grp_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grp_idx   <= '0;
      acc       <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      for (int k = 0; k < 4; k++) begin
        t_r[k] <= '0;
        b_r[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            t_r[0]   <= ha_array_0_t;
            t_r[1]   <= ha_array_1_t;
            t_r[2]   <= ha_array_2_t;
            t_r[3]   <= ha_array_3_t;
            b_r[0]   <= ha_array_0_b;
            b_r[1]   <= ha_array_1_b;
            b_r[2]   <= ha_array_2_b;
            b_r[3]   <= ha_array_3_b;
            acc      <= '0;
            grp_idx  <= '0;
            in_ready <= 1'b0;
            state    <= ACC;
          end
        end

        ACC: begin
          acc     <= acc + add_sum;
          grp_idx <= grp_idx + STEP;
          if (last_step) begin
            // product is loaded only here so it keeps its old value in
            // IDLE and ACC.
            product   <= acc + add_sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
